// File: rtl/register_file_param_if.sv
// Register-file bus: write port, two read ports, clear-sweep control.
// Parameters must match the register_file_param instance that uses it.
interface register_file_param_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 3
);
   logic                  we;
   logic [ADDR_WIDTH-1:0] wAddr;
   logic [DATA_WIDTH-1:0] wData;
   logic                  re0;
   logic                  re1;
   logic [ADDR_WIDTH-1:0] rAddr0;
   logic [ADDR_WIDTH-1:0] rAddr1;
   logic [DATA_WIDTH-1:0] rData0;
   logic [DATA_WIDTH-1:0] rData1;
   logic                  rValid0;
   logic                  rValid1;
   logic                  clr;
   logic                  busy;

   modport master (
      output we, wAddr, wData, re0, re1, rAddr0, rAddr1, clr,
      input  rData0, rData1, rValid0, rValid1, busy
   );

   modport slave (
      input  we, wAddr, wData, re0, re1, rAddr0, rAddr1, clr,
      output rData0, rData1, rValid0, rValid1, busy
   );
endinterface

// File: rtl/register_file_param.sv
// Parametrised register file: 1 write port, 2 registered read ports, clear sweeper.
// Optional macro REGFILE_BYPASS_EN forwards same-edge write data to a matching read.

module register_file_param_rdport #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_re,
   input  logic [DATA_WIDTH-1:0] i_word,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid
);
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;

   // Data holds its last value when the port is idle; only valid drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_re;
         if (i_re) r_data <= i_word;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
endmodule

module register_file_param #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   register_file_param_if.slave  bus
);
   localparam int NUM_PORTS = 2;
   localparam int DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                         r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0]          r_ptr, w_ptr_nxt;
   logic                           w_busy;
   logic                           w_wr_acc;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;

   logic [NUM_PORTS-1:0]                 w_re;
   logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] w_raddr;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_word;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_rdata;
   logic [NUM_PORTS-1:0]                 w_rvalid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // Sweep ends by comparing against the last address, so ptr may wrap harmlessly.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.clr) begin
               w_state_nxt = S_CLEAR;
               w_ptr_nxt   = '0;
            end
         end
         S_CLEAR: begin
            w_busy    = 1'b1;
            w_ptr_nxt = r_ptr + 1'b1;
            if (r_ptr == LAST) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Writes arriving during a sweep are silently dropped.
   assign w_wr_acc = bus.we & ~w_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem <= '0;
      end else if (w_busy) begin
         r_mem[r_ptr] <= '0;
      end else if (w_wr_acc) begin
         r_mem[bus.wAddr] <= bus.wData;
      end
   end

   assign w_re[0]    = bus.re0;
   assign w_re[1]    = bus.re1;
   assign w_raddr[0] = bus.rAddr0;
   assign w_raddr[1] = bus.rAddr1;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
      assign w_word[g] = (w_wr_acc && (bus.wAddr == w_raddr[g])) ? bus.wData
                                                                   : r_mem[w_raddr[g]];
`else
      assign w_word[g] = r_mem[w_raddr[g]];
`endif
      register_file_param_rdport #(.DATA_WIDTH(DATA_WIDTH)) u_rd (
         .clk     (clk),
         .reset   (reset),
         .i_re    (w_re[g]),
         .i_word  (w_word[g]),
         .o_data  (w_rdata[g]),
         .o_valid (w_rvalid[g])
      );
   end

   assign bus.rData0  = w_rdata[0];
   assign bus.rData1  = w_rdata[1];
   assign bus.rValid0 = w_rvalid[0];
   assign bus.rValid1 = w_rvalid[1];
   assign bus.busy    = w_busy;
endmodule

// File: tb/tb_register_file_param.sv
// Directed vector table plus hand-written sweep/reset sequences for register_file_param.
module tb_register_file_param;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rst8 = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   register_file_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus0();
   register_file_param_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4)) bus8();

   register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) u_dut (
      .clk(clk), .reset(rst), .bus(bus0.slave));
   register_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_dut8 (
      .clk(clk), .reset(rst8), .bus(bus8.slave));

`ifdef REGFILE_BYPASS_EN
   localparam logic [31:0] RDW_EXP = 32'ha5a5a5a5;
`else
   localparam logic [31:0] RDW_EXP = 32'h0000ffff;
`endif

   typedef struct {
      logic        rst, we;
      logic [2:0]  wa;
      logic [31:0] wd;
      logic        re0;
      logic [2:0]  ra0;
      logic        re1;
      logic [2:0]  ra1;
      logic        xv0;
      logic [31:0] xd0;
      logic        xv1;
      logic [31:0] xd1;
      logic        c0, c1;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic r, logic we, logic [2:0] wa, logic [31:0] wd,
                               logic re0, logic [2:0] ra0, logic re1, logic [2:0] ra1,
                               logic xv0, logic [31:0] xd0, logic xv1, logic [31:0] xd1);
      vec_t v;
      v.rst = r; v.we = we; v.wa = wa; v.wd = wd;
      v.re0 = re0; v.ra0 = ra0; v.re1 = re1; v.ra1 = ra1;
      v.xv0 = xv0; v.xd0 = xd0; v.xv1 = xv1; v.xd1 = xd1;
      v.c0 = xv0; v.c1 = xv1;
      return v;
   endfunction

   function automatic logic [31:0] fill(int i);
      if (i == 7) return 32'hffff0000;
      return (32'h1 << (4 * (i + 1))) - 32'h1;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle0();
      bus0.we = 0; bus0.wAddr = 0; bus0.wData = 0;
      bus0.re0 = 0; bus0.rAddr0 = 0; bus0.re1 = 0; bus0.rAddr1 = 0;
      bus0.clr = 0;
   endtask

   task automatic read_all_zero(string tag);
      for (int a = 0; a < 8; a++) begin
         bus0.re0 = 1; bus0.rAddr0 = 3'(a);
         bus0.re1 = 1; bus0.rAddr1 = 3'(7 - a);
         step();
         check($sformatf("%s rd0[%0d]", tag, a), bus0.rData0, 32'h0);
         check($sformatf("%s rd1[%0d]", tag, 7 - a), bus0.rData1, 32'h0);
         check($sformatf("%s rv0[%0d]", tag, a), {31'h0, bus0.rValid0}, 32'h1);
      end
      idle0();
   endtask

   int bc;

   initial begin
      idle0();
      bus8.we = 0; bus8.wAddr = 0; bus8.wData = 0; bus8.clr = 0;
      bus8.re0 = 0; bus8.rAddr0 = 0; bus8.re1 = 0; bus8.rAddr1 = 0;

      // ---- vector table ----
      vt.push_back(mk(1, 1, 3'd1, 32'hdead, 1, 3'd1, 1, 3'd2, 0, 0, 0, 0));
      vt[vt.size()-1].c0 = 1; vt[vt.size()-1].c1 = 1;
      for (int i = 0; i < 8; i++)
         vt.push_back(mk(0, 0, 0, 0, 1, 3'(i), 0, 0, 1, 32'h0, 0, 0));
      for (int i = 0; i < 8; i++)
         vt.push_back(mk(0, 1, 3'(i), fill(i), 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 8; i++)
         vt.push_back(mk(0, 0, 0, 0, 1, 3'(i), 1, 3'(7 - i), 1, fill(i), 1, fill(7 - i)));
      vt.push_back(mk(0, 0, 0, 0, 0, 3'd4, 1, 3'd2, 0, 0, 1, fill(2)));
      vt.push_back(mk(0, 0, 0, 0, 1, 3'd5, 0, 3'd2, 1, fill(5), 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 1, 3'd3, 32'ha5a5a5a5, 1, 3'd3, 1, 3'd4, 1, RDW_EXP, 1, fill(4)));
      vt.push_back(mk(0, 0, 0, 0, 1, 3'd3, 1, 3'd3, 1, 32'ha5a5a5a5, 1, 32'ha5a5a5a5));

      for (int k = 0; k < vt.size(); k++) begin
         rst = vt[k].rst; bus0.we = vt[k].we; bus0.wAddr = vt[k].wa; bus0.wData = vt[k].wd;
         bus0.re0 = vt[k].re0; bus0.rAddr0 = vt[k].ra0;
         bus0.re1 = vt[k].re1; bus0.rAddr1 = vt[k].ra1;
         step();
         check($sformatf("vec%0d rValid0", k), {31'h0, bus0.rValid0}, {31'h0, vt[k].xv0});
         check($sformatf("vec%0d rValid1", k), {31'h0, bus0.rValid1}, {31'h0, vt[k].xv1});
         check($sformatf("vec%0d busy", k), {31'h0, bus0.busy}, 32'h0);
         if (vt[k].c0) check($sformatf("vec%0d rData0", k), bus0.rData0, vt[k].xd0);
         if (vt[k].c1) check($sformatf("vec%0d rData1", k), bus0.rData1, vt[k].xd1);
      end
      rst = 0;
      idle0();

      // ---- clear sweep with dropped write and mid-sweep read ----
      bus0.clr = 1;
      step();
      bus0.clr = 0;
      check("clr busy rise", {31'h0, bus0.busy}, 32'h1);
      bc = 0;
      while (bus0.busy && bc < 40) begin
         bc++;
         if (bc == 2) begin bus0.we = 1; bus0.wAddr = 3'd5; bus0.wData = 32'h12345678; end
         if (bc == 3) begin bus0.re0 = 1; bus0.rAddr0 = 3'd7; end
         step();
         if (bc == 3) begin
            check("busy rd reg7", bus0.rData0, 32'hffff0000);
            check("busy rv0", {31'h0, bus0.rValid0}, 32'h1);
         end
         idle0();
      end
      check("clr busy cycles", 32'(bc), 32'd8);
      read_all_zero("post-clr");
      bus0.we = 1; bus0.wAddr = 3'd1; bus0.wData = 32'h77;
      step();
      idle0();
      bus0.re0 = 1; bus0.rAddr0 = 3'd1;
      step();
      check("post-clr write", bus0.rData0, 32'h77);
      idle0();

      // ---- back-to-back clr restarts on first idle edge ----
      bus0.clr = 1;
      step();
      bc = 0;
      while (bus0.busy && bc < 40) begin bc++; step(); end
      check("b2b first sweep", 32'(bc), 32'd8);
      check("b2b idle gap", {31'h0, bus0.busy}, 32'h0);
      step();
      check("b2b restart", {31'h0, bus0.busy}, 32'h1);
      bus0.clr = 0;
      bc = 0;
      while (bus0.busy && bc < 40) begin bc++; step(); end
      check("b2b second sweep", 32'(bc), 32'd8);

      // ---- reset mid-sweep ----
      bus0.we = 1; bus0.wAddr = 3'd6; bus0.wData = 32'h66;
      step();
      idle0();
      bus0.re0 = 1; bus0.rAddr0 = 3'd6; bus0.re1 = 1; bus0.rAddr1 = 3'd6;
      step();
      check("pre-rst rd6", bus0.rData0, 32'h66);
      idle0();
      bus0.clr = 1;
      step();
      bus0.clr = 0;
      bc = 1;
      while (bus0.busy && bc < 4) begin bc++; step(); end
      check("rst reached busy cycle 4", 32'(bc), 32'd4);
      rst = 1; bus0.re0 = 1; bus0.re1 = 1; bus0.we = 1; bus0.wAddr = 3'd6;
      bus0.wData = 32'hdead; bus0.clr = 1;
      step();
      rst = 0;
      idle0();
      check("rst busy", {31'h0, bus0.busy}, 32'h0);
      check("rst rv0", {31'h0, bus0.rValid0}, 32'h0);
      check("rst rv1", {31'h0, bus0.rValid1}, 32'h0);
      check("rst rd0", bus0.rData0, 32'h0);
      check("rst rd1", bus0.rData1, 32'h0);
      step();
      check("rst stays idle", {31'h0, bus0.busy}, 32'h0);
      read_all_zero("post-rst");

      // ---- 8-bit x 16 instance ----
      rst8 = 1;
      step();
      rst8 = 0;
      bus8.we = 1; bus8.wAddr = 4'd15; bus8.wData = 8'hff;
      step();
      bus8.we = 0;
      bus8.re0 = 1; bus8.rAddr0 = 4'd15; bus8.re1 = 1; bus8.rAddr1 = 4'd14;
      step();
      bus8.re0 = 0; bus8.re1 = 0;
      check("p8 rd15", {24'h0, bus8.rData0}, 32'hff);
      check("p8 rd14", {24'h0, bus8.rData1}, 32'h0);
      check("p8 rv0", {31'h0, bus8.rValid0}, 32'h1);
      bus8.clr = 1;
      step();
      bus8.clr = 0;
      bc = 0;
      while (bus8.busy && bc < 40) begin bc++; step(); end
      check("p8 busy cycles", 32'(bc), 32'd16);
      bus8.re0 = 1; bus8.rAddr0 = 4'd15;
      step();
      bus8.re0 = 0;
      check("p8 rd15 cleared", {24'h0, bus8.rData0}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
